// File: rtl/legv8_fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package legv8_fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low bits of a target are ignored.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of {pc, inst} entries between instruction memory and decode.
// Clear wins over push/pop; an empty buffer presents an all-zero head.
module fetch_buf
    import legv8_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic             i_push,
    input  fetch_entry_t     i_push_entry,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output fetch_entry_t     o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == LAST_PTR) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign w_pop  = i_pop && (r_count != {CNT_W{1'b0}});
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    // Pointer and occupancy tracking.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Head presentation, forced to zero when nothing is buffered.
    always_comb begin
        o_head = '0;
        if (r_count != {CNT_W{1'b0}}) begin
            o_head = r_mem[r_rd_ptr];
        end else begin
            o_head = '0;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, prefetches into fetch_buf under a credit limit,
// and redirects (flush + drop of stale responses) when NextPC is not sequential.
module inst_fetch_unit
    import legv8_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              resetl,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] Instruction,
    output logic [ADDR_W-1:0] CurrentPC,
    input  logic              inst_ready,
    input  logic [ADDR_W-1:0] NextPC
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;
    logic              w_consume;
    logic              w_flush;
    logic              w_accept;
    logic              w_drop;
    logic              w_push;
    logic [SUM_W-1:0]  w_credit_use;
    logic [CNT_W-1:0]  w_out_next;
    logic [ADDR_W-1:0] w_target_pc;

    assign inst_valid  = (w_count != {CNT_W{1'b0}});
    assign Instruction = w_head.inst;
    assign CurrentPC   = w_head.pc;

    assign w_consume   = inst_valid && inst_ready;
    assign w_flush     = w_consume && (NextPC != (w_head.pc + PC_INC));
    assign w_target_pc = align_pc(NextPC);

    // A slot freed by this cycle's pop may be re-requested immediately, keeping 1 inst/cycle.
    assign w_credit_use = SUM_W'(r_outstanding) + SUM_W'(w_count) - SUM_W'(w_consume);

    assign imem_req_valid = resetl && (w_credit_use < SUM_W'(BUF_DEPTH)) && !w_flush;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_drop = imem_rsp_valid && (r_drop_cnt != {CNT_W{1'b0}});
    assign w_push = imem_rsp_valid && !w_drop && !w_flush;

    assign w_push_entry.pc   = r_rsp_pc;
    assign w_push_entry.inst = imem_rsp_data;

    // In-flight count after this cycle's accept and response.
    always_comb begin
        w_out_next = r_outstanding;
        case ({w_accept, imem_rsp_valid})
            2'b10:   w_out_next = r_outstanding + CNT_W'(1);
            2'b01:   w_out_next = r_outstanding - CNT_W'(1);
            default: w_out_next = r_outstanding;
        endcase
    end

    // Request address and response address counters.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
        end else if (w_flush) begin
            r_fetch_pc <= w_target_pc;
            r_rsp_pc   <= w_target_pc;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + PC_INC;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + PC_INC;
            end
        end
    end

    // Outstanding and stale-response bookkeeping.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_outstanding <= {CNT_W{1'b0}};
            r_drop_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_outstanding <= w_out_next;
            if (w_flush) begin
                r_drop_cnt <= w_out_next;
            end else if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_buf (
        .CLK          (CLK),
        .resetl       (resetl),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_consume),
        .i_clear      (w_flush),
        .o_count      (w_count),
        .o_head       (w_head)
    );

endmodule
